// File: rtl/mipi_ccs_pkg.sv
// Shared types and constants for the CSI-2 pixel path.
// Format encoding matches the imx219 sensor model.
package mipi_ccs_pkg;

    typedef enum logic {
        FMT_RAW8  = 1'b0,
        FMT_RAW10 = 1'b1
    } pixel_fmt_t;

    localparam int RAW10_GROUP_BYTES  = 5;
    localparam int RAW10_GROUP_PIXELS = 4;
    localparam int PIXEL_WIDTH        = 10;

endpackage

// File: rtl/raw10_group_decode.sv
// Splits one 5-byte RAW10 group into four 10-bit pixels.
// Byte 4 carries the two LSBs of each pixel, pixel 0 in bits [1:0].
module raw10_group_decode
    import mipi_ccs_pkg::*;
(
    input  logic [8*RAW10_GROUP_BYTES-1:0]              group_bytes,
    output logic [PIXEL_WIDTH*RAW10_GROUP_PIXELS-1:0]   pixels
);

    localparam int LSB_BASE = 8 * (RAW10_GROUP_BYTES - 1);

    always_comb begin
        pixels = '0;
        for (int k = 0; k < RAW10_GROUP_PIXELS; k++) begin
            pixels[PIXEL_WIDTH*k +: PIXEL_WIDTH] =
                {group_bytes[8*k +: 8], group_bytes[LSB_BASE+2*k +: 2]};
        end
    end

endmodule

// File: rtl/raw_pixel_unpacker.sv
// Unpacks the CSI-2 long-packet payload byte stream into 10-bit pixels.
// RAW8 is zero-padded per beat; RAW10 is reassembled from 5-byte groups.
module raw_pixel_unpacker
    import mipi_ccs_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 format,
    input  logic                 in_line_start,
    input  logic                 in_line_end,
    input  logic                 in_valid,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 out_valid,
    output logic [39:0]          out_pixels,
    output logic [2:0]           out_count,
    output logic                 out_line_start,
    output logic                 out_line_end,
    output logic                 length_err
);

    localparam int BUF_BYTES = RAW10_GROUP_BYTES - 1 + LANES;
    localparam int FW        = $clog2(BUF_BYTES + 1);
    localparam int GW        = 8 * RAW10_GROUP_BYTES;
    localparam logic [FW-1:0] GRP   = FW'(RAW10_GROUP_BYTES);
    localparam logic [FW-1:0] LSTEP = FW'(LANES);

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("raw_pixel_unpacker: LANES must be 1, 2 or 4");
    end

    logic [8*BUF_BYTES-1:0] buf_q, buf_app, buf_n;
    logic [FW-1:0]          fill_q, fill_base, fill_app, fill_n;
    pixel_fmt_t             fmt_q, fmt_cur;
    logic                   active_q, active_cur, active_n;
    logic                   first_q, first_cur, first_n;
    logic                   err_n;
    logic                   take, take10, emit10;
    logic                   valid_n, ls_n;
    logic [39:0]            raw8_pix, group_pix, pix_n;
    logic [2:0]             cnt_n;

    raw10_group_decode u_decode (
        .group_bytes (buf_app[GW-1:0]),
        .pixels      (group_pix)
    );

    // A line start wipes residue before this cycle's beat is appended.
    always_comb begin
        buf_app    = in_line_start ? '0 : buf_q;
        fill_base  = in_line_start ? '0 : fill_q;
        fmt_cur    = in_line_start ? pixel_fmt_t'(format) : fmt_q;
        active_cur = in_line_start | active_q;
        first_cur  = in_line_start | first_q;
        take       = in_valid & active_cur;
        take10     = take & (fmt_cur == FMT_RAW10);

        for (int i = 0; i < BUF_BYTES; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if (take10 && (int'(fill_base) + j == i)) begin
                    buf_app[8*i +: 8] = in_data[8*j +: 8];
                end
            end
        end

        fill_app = take10 ? fill_base + LSTEP : fill_base;
        emit10   = fill_app >= GRP;
        buf_n    = emit10 ? (buf_app >> GW) : buf_app;
        fill_n   = emit10 ? fill_app - GRP : fill_app;

        raw8_pix = '0;
        for (int j = 0; j < LANES; j++) begin
            raw8_pix[PIXEL_WIDTH*j +: PIXEL_WIDTH] = {in_data[8*j +: 8], 2'b00};
        end

        valid_n = emit10 | (take & (fmt_cur == FMT_RAW8));
        pix_n   = emit10 ? group_pix : (valid_n ? raw8_pix : '0);
        cnt_n   = emit10 ? 3'(RAW10_GROUP_PIXELS) : (valid_n ? 3'(LANES) : 3'd0);
        ls_n    = valid_n & first_cur;
        first_n = first_cur & ~valid_n;
        err_n    = length_err;
        active_n = active_cur;

        if (in_line_end) begin
            if (fill_n != '0) begin
                err_n = 1'b1;
            end
            fill_n   = '0;
            buf_n    = '0;
            active_n = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            buf_q          <= '0;
            fill_q         <= '0;
            fmt_q          <= FMT_RAW8;
            active_q       <= 1'b0;
            first_q        <= 1'b1;
            out_valid      <= 1'b0;
            out_pixels     <= '0;
            out_count      <= '0;
            out_line_start <= 1'b0;
            out_line_end   <= 1'b0;
            length_err     <= 1'b0;
        end else begin
            buf_q          <= buf_n;
            fill_q         <= fill_n;
            fmt_q          <= fmt_cur;
            active_q       <= active_n;
            first_q        <= first_n;
            out_valid      <= valid_n;
            out_pixels     <= pix_n;
            out_count      <= cnt_n;
            out_line_start <= ls_n;
            out_line_end   <= in_line_end;
            length_err     <= err_n;
        end
    end

endmodule

// File: tb/tb_raw_pixel_unpacker.sv
// Bench for raw_pixel_unpacker: LANES=2 and LANES=4 instances checked
// against a queue-based model plus hand-computed literal cases.
module tb_raw_pixel_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        fm, ls, le, vld;
    logic [15:0]       d2;
    logic [31:0]       d4;
    logic [1:0]        ov, ols, ole, oerr;
    logic [1:0][39:0]  op;
    logic [1:0][2:0]   oc;

    int total = 0;
    int bad   = 0;

    raw_pixel_unpacker #(.LANES(2)) u2 (
        .clk_in(clk), .reset_n(rst_n), .format(fm[0]),
        .in_line_start(ls[0]), .in_line_end(le[0]), .in_valid(vld[0]),
        .in_data(d2), .out_valid(ov[0]), .out_pixels(op[0]),
        .out_count(oc[0]), .out_line_start(ols[0]),
        .out_line_end(ole[0]), .length_err(oerr[0])
    );

    raw_pixel_unpacker #(.LANES(4)) u4 (
        .clk_in(clk), .reset_n(rst_n), .format(fm[1]),
        .in_line_start(ls[1]), .in_line_end(le[1]), .in_valid(vld[1]),
        .in_data(d4), .out_valid(ov[1]), .out_pixels(op[1]),
        .out_count(oc[1]), .out_line_start(ols[1]),
        .out_line_end(ole[1]), .length_err(oerr[1])
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: payload bytes of the open line kept in a queue.
    logic [7:0]  mq[2][$];
    bit          m_fmt[2], m_act[2], m_first[2], m_err[2];
    bit          e_v[2], e_ls[2], e_le[2];
    int          e_cnt[2];
    logic [39:0] e_pix[2];

    task automatic model_step(int id);
        int          nl;
        logic [31:0] dd;
        logic [7:0]  g[5];
        nl = (id == 1) ? 4 : 2;
        dd = (id == 1) ? d4 : {16'h0, d2};
        e_v[id]   = 1'b0;
        e_ls[id]  = 1'b0;
        e_cnt[id] = 0;
        e_pix[id] = '0;
        e_le[id]  = le[id];
        if (!rst_n) begin
            mq[id].delete();
            m_fmt[id] = 1'b0; m_act[id] = 1'b0;
            m_first[id] = 1'b1; m_err[id] = 1'b0;
            e_le[id] = 1'b0;
            return;
        end
        if (ls[id]) begin
            mq[id].delete();
            m_fmt[id] = fm[id]; m_act[id] = 1'b1; m_first[id] = 1'b1;
        end
        if (vld[id] && m_act[id]) begin
            if (!m_fmt[id]) begin
                e_v[id] = 1'b1;
                e_cnt[id] = nl;
                for (int j = 0; j < nl; j++)
                    e_pix[id][10*j +: 10] = 10'(dd[8*j +: 8]) * 10'd4;
            end else begin
                for (int j = 0; j < nl; j++) mq[id].push_back(dd[8*j +: 8]);
                if (mq[id].size() >= 5) begin
                    for (int k = 0; k < 5; k++) g[k] = mq[id].pop_front();
                    for (int k = 0; k < 4; k++)
                        e_pix[id][10*k +: 10] = 10'(g[k]) * 10'd4
                            + 10'((g[4] >> (2*k)) & 8'd3);
                    e_v[id] = 1'b1;
                    e_cnt[id] = 4;
                end
            end
        end
        if (e_v[id]) begin
            e_ls[id] = m_first[id];
            m_first[id] = 1'b0;
        end
        if (le[id]) begin
            if (mq[id].size() != 0) m_err[id] = 1'b1;
            mq[id].delete();
            m_act[id] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        for (int id = 0; id < 2; id++) begin
            if (!rst_n) begin
                chk($sformatf("rst_outs%0d", id),
                    {ov[id], oc[id], ols[id], ole[id], oerr[id], op[id]}, '0);
            end else begin
                chk($sformatf("ctl%0d", id), {ov[id], ole[id], oerr[id]},
                    {e_v[id], e_le[id], m_err[id]});
                if (e_v[id])
                    chk($sformatf("dat%0d", id), {oc[id], ols[id], op[id]},
                        {3'(e_cnt[id]), e_ls[id], e_pix[id]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        ls = '0; le = '0; vld = '0;
    endtask

    // Bytes 12 34 56 78 E4 twice on the LANES=2 instance.
    task automatic raw10_demo(bit toggle);
        logic [39:0] want;
        want = {10'h1E3, 10'h15A, 10'h0D1, 10'h048};
        fm[0] = 1'b1; ls[0] = 1'b1; vld[0] = 1'b1; d2 = 16'h3412;
        tick();
        ls[0] = 1'b0; d2 = 16'h7856;
        if (toggle) fm[0] = 1'b0;
        tick();
        d2 = 16'h12E4;
        tick();
        chk("r10_g1_valid", ov[0], 1'b1);
        chk("r10_g1_pix", op[0], want);
        chk("r10_g1_cnt_ls", {oc[0], ols[0]}, {3'd4, 1'b1});
        d2 = 16'h5634;
        tick();
        chk("r10_gap", ov[0], 1'b0);
        d2 = 16'hE478; le[0] = 1'b1;
        tick();
        chk("r10_g2_pix", op[0], want);
        chk("r10_g2_flags", {ov[0], oc[0], ols[0], ole[0]}, {1'b1, 3'd4, 1'b0, 1'b1});
        idle();
        tick();
        chk("r10_end", {ole[0], oerr[0]}, 2'b00);
    endtask

    // 20-byte RAW10 line on the LANES=4 instance.
    task automatic line4(output int nv, output int nle);
        nv = 0; nle = 0;
        fm[1] = 1'b1; ls[1] = 1'b1;
        for (int b = 0; b < 5; b++) begin
            vld[1] = 1'b1; d4 = $urandom; le[1] = (b == 4);
            tick();
            ls[1] = 1'b0;
            nv += int'(ov[1]); nle += int'(ole[1]);
        end
        idle();
        tick();
        nv += int'(ov[1]); nle += int'(ole[1]);
    endtask

    initial begin
        int nv, nle, nb;
        rst_n = 1'b0; fm = '0; d2 = '0; d4 = '0;
        idle();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("reset_valid", ov, 2'b00);
        chk("reset_err", oerr, 2'b00);
        chk("reset_cnt", {oc[1], oc[0]}, 6'd0);

        raw10_demo(1'b0);

        fm[0] = 1'b0; ls[0] = 1'b1; vld[0] = 1'b1; d2 = 16'hBBAA;
        tick();
        chk("raw8_valid_cnt", {ov[0], oc[0], ols[0]}, {1'b1, 3'd2, 1'b1});
        chk("raw8_pix", op[0], {20'h0, 10'h2EC, 10'h2A8});
        idle(); le[0] = 1'b1;
        tick();
        idle();
        tick();

        line4(nv, nle);
        chk("l4_groups", nv, 4);
        chk("l4_line_end", nle, 1);
        chk("l4_err", oerr[1], 1'b0);

        fm[1] = 1'b1; ls[1] = 1'b1; vld[1] = 1'b1; d4 = $urandom;
        tick();
        ls[1] = 1'b0; d4 = $urandom; le[1] = 1'b1;
        tick();
        chk("res_group", ov[1], 1'b1);
        idle();
        tick();
        chk("res_err_set", oerr[1], 1'b1);
        line4(nv, nle);
        chk("res_err_sticky", oerr[1], 1'b1);

        raw10_demo(1'b1);

        fm[0] = 1'b1; ls[0] = 1'b1; vld[0] = 1'b1; d2 = 16'h3412;
        tick();
        ls[0] = 1'b0; d2 = 16'h7856;
        tick();
        d2 = 16'h12E4;
        tick();
        rst_n = 1'b0;
        idle();
        #1;
        chk("rst_mid_valid", ov[0], 1'b0);
        chk("rst_clears_err", oerr[1], 1'b0);
        tick();
        rst_n = 1'b1;
        raw10_demo(1'b0);

        for (int n = 0; n < 80; n++) begin
            nb = $urandom_range(1, 14);
            fm = $urandom_range(0, 1) ? 2'b11 : 2'b00;
            ls = '1;
            for (int b = 0; b < nb; b++) begin
                if ((n % 17) == 5 && b == nb / 2) begin
                    idle();
                    rst_n = 1'b0;
                    tick();
                    rst_n = 1'b1;
                end
                vld = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'b00;
                d4 = $urandom; d2 = 16'($urandom);
                if (b > 0 && $urandom_range(0, 3) == 0) fm = 2'($urandom);
                le = (b == nb - 1 && $urandom_range(0, 7) != 0) ? 2'b11 : 2'b00;
                tick();
                ls = '0;
            end
            idle();
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                vld = 2'($urandom); d4 = $urandom; d2 = 16'($urandom);
                tick();
            end
            idle();
        end

        idle();
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
